// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search controller.
// Holds the FSM state encoding, the comparator flag triple and its legality check.
// Imported by the top module; contains no logic of its own.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    PROBE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

  // A legal comparator answer has exactly one of eq/lt/gt set.
  function automatic logic onehot3(input cmp_result_t r);
    logic ok;
    case ({r.eq, r.lt, r.gt})
      3'b100, 3'b010, 3'b001: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sar_search_32bits.sv
// Binary-search controller driving an external magnitude comparator to locate a hidden target in [lo, hi].
// Latency: 2 cycles per iteration with zero-latency ack (CALC + PROBE), at most WIDTH+1 comparisons, plus 1 DONE cycle.
// Backpressure: o_cmp_req and o_cmp_operand hold stable until i_cmp_ack; i_start is ignored unless IDLE.
module sar_search_32bits
  import sar_search_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = $clog2(WIDTH + 2)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [WIDTH-1:0]  i_lo,
  input  logic [WIDTH-1:0]  i_hi,
  output logic              o_busy,
  output logic              o_cmp_req,
  output logic [WIDTH-1:0]  o_cmp_operand,
  input  logic              i_cmp_ack,
  input  logic              i_cmp_eq,
  input  logic              i_cmp_lt,
  input  logic              i_cmp_gt,
  output logic              o_done,
  output logic              o_found,
  output logic              o_error,
  output logic [WIDTH-1:0]  o_result,
  output logic [ITER_W-1:0] o_iters
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_mid;
  logic [ITER_W-1:0]  r_iters;
  logic               r_found;
  logic               r_error;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   w_mid;
  cmp_result_t        w_flags;
  logic               w_legal;

  // Midpoint written as lo + half-span so it never overflows WIDTH bits.
  assign w_mid   = r_lo + ((r_hi - r_lo) >> 1);
  assign w_flags = '{eq: i_cmp_eq, lt: i_cmp_lt, gt: i_cmp_gt};
  assign w_legal = onehot3(w_flags);

  // Outputs decode straight from the state register so an async reset drops req at once.
  assign o_busy        = (r_state == CALC) || (r_state == PROBE);
  assign o_cmp_req     = (r_state == PROBE);
  assign o_done        = (r_state == DONE);
  assign o_cmp_operand = r_mid;
  assign o_found       = r_found;
  assign o_error       = r_error;
  assign o_result      = r_result;
  assign o_iters       = r_iters;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; the mid==hi / mid==lo guards end the search before lo/hi could wrap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = (i_lo > i_hi) ? DONE : CALC;
      end
      CALC: w_state_nxt = PROBE;
      PROBE: begin
        if (i_cmp_ack) begin
          if (!w_legal)          w_state_nxt = DONE;
          else if (w_flags.eq)   w_state_nxt = DONE;
          else if (w_flags.lt)   w_state_nxt = (r_mid == r_hi) ? DONE : CALC;
          else                   w_state_nxt = (r_mid == r_lo) ? DONE : CALC;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Search bounds, probe operand and held results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_mid    <= '0;
      r_iters  <= '0;
      r_found  <= 1'b0;
      r_error  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_lo     <= i_lo;
            r_hi     <= i_hi;
            r_iters  <= '0;
            r_found  <= 1'b0;
            r_error  <= 1'b0;
            r_result <= '0;
          end
        end
        CALC: r_mid <= w_mid;
        PROBE: begin
          if (i_cmp_ack) begin
            r_iters <= r_iters + ITER_W'(1);
            if (!w_legal) begin
              r_error <= 1'b1;
            end else if (w_flags.eq) begin
              r_found  <= 1'b1;
              r_result <= r_mid;
            end else if (w_flags.lt) begin
              if (r_mid != r_hi) r_lo <= r_mid + WIDTH'(1);
            end else begin
              if (r_mid != r_lo) r_hi <= r_mid - WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_32bits.sv
// Directed bench for sar_search_32bits with a behavioural comparator on operand_b = target.
// Ack is either tied to the request or delayed three cycles; flags can be forced illegal.
// Outputs are sampled on the falling edge; inputs also change on the falling edge.
module tb_sar_search_32bits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] lo_in;
  logic [31:0] hi_in;
  logic        busy;
  logic        cmp_req;
  logic [31:0] cmp_operand;
  logic        cmp_ack;
  logic        cmp_eq;
  logic        cmp_lt;
  logic        cmp_gt;
  logic        done;
  logic        found;
  logic        err;
  logic [31:0] result;
  logic [5:0]  iters;

  logic [31:0] target = '0;
  bit          ack_delay = 1'b0;
  bit          bad_flags = 1'b0;
  int          wait_cnt = 0;

  int          n_pass = 0;
  int          n_total = 0;

  logic [31:0] probes[$];
  bit          req_seen;
  int          viol;
  int          done_cycle;
  bit          done_seen;

  always #5 clk = ~clk;

  // Comparator model: operand_a is the probe, operand_b the hidden target.
  assign cmp_eq  = bad_flags ? 1'b1 : (cmp_operand == target);
  assign cmp_lt  = bad_flags ? 1'b1 : (cmp_operand <  target);
  assign cmp_gt  = bad_flags ? 1'b0 : (cmp_operand >  target);
  assign cmp_ack = ack_delay ? (cmp_req && (wait_cnt == 3)) : cmp_req;

  // Counts cycles the current request has been waiting.
  always @(posedge clk) begin
    if (!cmp_req || cmp_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  sar_search_32bits dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_lo          (lo_in),
    .i_hi          (hi_in),
    .o_busy        (busy),
    .o_cmp_req     (cmp_req),
    .o_cmp_operand (cmp_operand),
    .i_cmp_ack     (cmp_ack),
    .i_cmp_eq      (cmp_eq),
    .i_cmp_lt      (cmp_lt),
    .i_cmp_gt      (cmp_gt),
    .o_done        (done),
    .o_found       (found),
    .o_error       (err),
    .o_result      (result),
    .o_iters       (iters)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start a search and follow it to o_done, logging acked probes and handshake violations.
  // restart_at > 0 pulses a conflicting start that many cycles into the search.
  task automatic run(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] tgt,
                     input bit dly, input int restart_at);
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_op;
    target    = tgt;
    ack_delay = dly;
    probes.delete();
    req_seen  = 1'b0;
    viol      = 0;
    done_seen = 1'b0;
    done_cycle = -1;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_op   = '0;
    @(negedge clk);
    lo_in = lo;
    hi_in = hi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (cmp_req) req_seen = 1'b1;
      if (prev_req && !prev_ack && cmp_req && (cmp_operand != prev_op)) viol++;
      if (prev_ack && cmp_req) viol++;
      if (cmp_req && cmp_ack) probes.push_back(cmp_operand);
      prev_req = cmp_req;
      prev_ack = cmp_ack;
      prev_op  = cmp_operand;
      if (done) begin
        done_seen  = 1'b1;
        done_cycle = c;
        break;
      end
      if (c == restart_at) begin
        start = 1'b1;
        lo_in = 32'd0;
        hi_in = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_reached", {63'd0, done_seen}, 64'd1);
  endtask

  initial begin
    int mono_viol;
    int done_cnt;
    bit req_up;

    rst_n = 1'b0;
    start = 1'b0;
    lo_in = '0;
    hi_in = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {busy, cmp_req, done, found, err}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_iters", {58'd0, iters}, 64'd0);
    check("rst_operand", {32'd0, cmp_operand}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full range, target 0: probes 2^(32-k)-1 for k = 1..32.
    run(32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    check("t0_found", {63'd0, found}, 64'd1);
    check("t0_result", {32'd0, result}, 64'd0);
    check("t0_iters", {58'd0, iters}, 64'd32);
    check("t0_nprobes", probes.size(), 64'd32);
    check("t0_probe0", {32'd0, probes[0]}, 64'h7FFF_FFFF);
    check("t0_probe1", {32'd0, probes[1]}, 64'h3FFF_FFFF);
    check("t0_probe31", {32'd0, probes[31]}, 64'd0);
    check("t0_handshake", viol, 64'd0);
    // Results hold after o_done.
    repeat (3) @(negedge clk);
    check("t0_hold_found", {63'd0, found}, 64'd1);
    check("t0_hold_iters", {58'd0, iters}, 64'd32);
    check("t0_done_pulse", {63'd0, done}, 64'd0);

    // Full range, target max: 33 strictly rising probes, no wrap to 0.
    run(32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("tmax_found", {63'd0, found}, 64'd1);
    check("tmax_result", {32'd0, result}, 64'hFFFF_FFFF);
    check("tmax_iters", {58'd0, iters}, 64'd33);
    mono_viol = 0;
    for (int i = 1; i < probes.size(); i++)
      if (probes[i] <= probes[i-1]) mono_viol++;
    check("tmax_monotonic", mono_viol, 64'd0);

    // Target below the range: probes 15, 12, 10, then give up.
    run(32'd10, 32'd20, 32'd5, 1'b0, 0);
    check("oor_found", {63'd0, found}, 64'd0);
    check("oor_result", {32'd0, result}, 64'd0);
    check("oor_iters", {58'd0, iters}, 64'd3);
    check("oor_error", {63'd0, err}, 64'd0);
    check("oor_nprobes", probes.size(), 64'd3);
    check("oor_probe0", {32'd0, probes[0]}, 64'd15);
    check("oor_probe1", {32'd0, probes[1]}, 64'd12);
    check("oor_probe2", {32'd0, probes[2]}, 64'd10);

    // Empty range: straight from IDLE to DONE, visible in the cycle after the start cycle.
    run(32'd20, 32'd10, 32'd15, 1'b0, 0);
    check("empty_done_cycle", done_cycle, 64'd1);
    check("empty_busy", {63'd0, busy}, 64'd0);
    check("empty_req_seen", {63'd0, req_seen}, 64'd0);
    check("empty_found", {63'd0, found}, 64'd0);
    check("empty_iters", {58'd0, iters}, 64'd0);

    // Delayed ack with a conflicting start mid-search.
    run(32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 4);
    check("dly_found", {63'd0, found}, 64'd1);
    check("dly_result", {32'd0, result}, 64'h1234_5678);
    check("dly_stable", viol, 64'd0);
    check("dly_probe0", {32'd0, probes[0]}, 64'h7FFF_FFFF);
    check("dly_iters_match", {58'd0, iters}, probes.size());

    // Illegal eq+lt on the first ack.
    bad_flags = 1'b1;
    run(32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    bad_flags = 1'b0;
    check("bad_error", {63'd0, err}, 64'd1);
    check("bad_iters", {58'd0, iters}, 64'd1);
    check("bad_found", {63'd0, found}, 64'd0);

    // Asynchronous reset while a probe is waiting for ack.
    ack_delay = 1'b1;
    target    = 32'h0;
    @(negedge clk);
    lo_in = 32'h0;
    hi_in = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    req_up = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (cmp_req) begin
        req_up = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid_req_before", {63'd0, req_up}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req_drop", {63'd0, cmp_req}, 64'd0);
    check("rstmid_busy_drop", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || cmp_req) done_cnt++;
    end
    check("rstmid_no_done", done_cnt, 64'd0);
    check("rstmid_iters", {58'd0, iters}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
